// File: rtl/inputc_vcn_if.sv
// ============================================================================
// Module      : inputc_vcn_if
// Description : Link-in and switch-side handshake bundle for inputc_vcn.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface inputc_vcn_if #(
    parameter int VCH_N  = 2,
    parameter int DATA_W = 32
);
    localparam int VCH_W  = (VCH_N > 1) ? $clog2(VCH_N) : 1;
    localparam int PORT_W = 3;

    logic              in_valid;
    logic [VCH_W-1:0]  in_vch;
    logic [DATA_W-1:0] in_data;
    logic [VCH_N-1:0]  in_rdy;
    logic              req_o;
    logic [PORT_W-1:0] port_o;
    logic              lck_o;
    logic              grt_i;
    logic              out_valid;
    logic [VCH_W-1:0]  out_vch;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_vch, in_data, grt_i,
        input  in_rdy, req_o, port_o, lck_o, out_valid, out_vch, out_data
    );

    modport slave (
        input  in_valid, in_vch, in_data, grt_i,
        output in_rdy, req_o, port_o, lck_o, out_valid, out_vch, out_data
    );
endinterface

`default_nettype wire

// File: rtl/inputc_vcn.sv
// ============================================================================
// Module      : inputc_vcn
// Description : Router input channel with per-VC FIFOs, XY routing, wormhole
//               VC lock and round-robin VC selection. Optional per-VC pop
//               counters are built when NOC_INPUTC_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inputc_vcn #(
    parameter int VCH_N   = 2,
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 32,
    parameter int ARRAY_W = 2,
    parameter int PORT_N  = 5
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    inputc_vcn_if.slave                    bus,
    input  wire logic [ARRAY_W-1:0]        my_xpos,
    input  wire logic [ARRAY_W-1:0]        my_ypos,
    input  wire logic [PORT_N*VCH_N-1:0]   dn_rdy,
    output logic                           overflow_o,
    output logic [VCH_N*16-1:0]            flit_cnt_o
);
    localparam int VCH_W = (VCH_N > 1) ? $clog2(VCH_N) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] c_T_NONE     = 3'b000;
    localparam logic [2:0] c_T_HEAD     = 3'b001;
    localparam logic [2:0] c_T_TAIL     = 3'b011;
    localparam logic [2:0] c_T_HEADTAIL = 3'b100;

    typedef enum logic [0:0] {ST_FREE = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t            r_state, w_state_nx;
    logic [VCH_W-1:0]  r_lock_vc, w_lock_vc_nx;
    logic [VCH_W-1:0]  r_ptr, w_ptr_nx;
    logic [VCH_W-1:0]  w_sel, w_cand;
    logic              w_found, w_req, w_pop;
    logic [2:0]        w_pop_type;
    logic [DATA_W-1:0] w_head [VCH_N];
    logic [2:0]        w_route [VCH_N];
    logic [VCH_N-1:0]  w_elig, w_wr, w_rd, w_full_hit, w_in_rdy;
    logic [2:0]        w_in_type;

    logic              r_out_valid, r_ovf;
    logic [VCH_W-1:0]  r_out_vch;
    logic [DATA_W-1:0] r_out_data;

    assign w_in_type = bus.in_data[DATA_W-1 -: 3];

    for (genvar v = 0; v < VCH_N; v++) begin : g_vc
        logic [DATA_W-1:0] r_mem [DEPTH];
        logic [PTR_W-1:0]  r_wptr, r_rptr;
        logic [CNT_W-1:0]  r_cnt;
        logic              r_rdy, r_rvld;
        logic [2:0]        r_route, w_xy, w_htype;
        logic [PORT_N-1:0] w_dn_sel;
        logic              w_sel_vc, w_nz;
        logic [ARRAY_W-1:0] w_dx, w_dy;

        for (genvar p = 0; p < PORT_N; p++) begin : g_dn
            assign w_dn_sel[p] = dn_rdy[p*VCH_N+v];
        end

        assign w_sel_vc      = bus.in_valid && (bus.in_vch == VCH_W'(v)) && (w_in_type != c_T_NONE);
        assign w_wr[v]       = w_sel_vc && (r_cnt < CNT_W'(DEPTH));
        // A same-cycle pop does not free a slot for a write to a full FIFO.
        assign w_full_hit[v] = w_sel_vc && (r_cnt == CNT_W'(DEPTH));
        assign w_rd[v]       = w_pop && (w_sel == VCH_W'(v));
        assign w_nz          = (r_cnt != '0);
        assign w_head[v]     = r_mem[r_rptr];
        assign w_htype       = r_mem[r_rptr][DATA_W-1 -: 3];
        assign w_route[v]    = r_route;
        assign w_elig[v]     = w_nz && r_rvld && w_dn_sel[r_route];
        assign w_in_rdy[v]   = r_rdy;
        assign w_dx          = r_mem[r_rptr][2*ARRAY_W-1:ARRAY_W];
        assign w_dy          = r_mem[r_rptr][ARRAY_W-1:0];

        always_comb begin
            w_xy = 3'd0;
            if (w_dx > my_xpos)      w_xy = 3'd2;
            else if (w_dx < my_xpos) w_xy = 3'd4;
            else if (w_dy > my_ypos) w_xy = 3'd3;
            else if (w_dy < my_ypos) w_xy = 3'd1;
        end

        always_ff @(posedge clk) begin
            if (w_wr[v]) r_mem[r_wptr] <= bus.in_data;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_cnt   <= '0;
                r_rdy   <= 1'b1;
                r_rvld  <= 1'b0;
                r_route <= 3'd0;
            end else begin
                if (w_wr[v]) r_wptr <= r_wptr + PTR_W'(1);
                if (w_rd[v]) r_rptr <= r_rptr + PTR_W'(1);
                case ({w_wr[v], w_rd[v]})
                    2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                    2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                    default: r_cnt <= r_cnt;
                endcase
                r_rdy <= (r_cnt < CNT_W'(DEPTH));
                if (w_rd[v] && (w_htype == c_T_TAIL || w_htype == c_T_HEADTAIL)) begin
                    r_rvld <= 1'b0;
                end else if (!r_rvld && w_nz && (w_htype == c_T_HEAD || w_htype == c_T_HEADTAIL)) begin
                    r_rvld  <= 1'b1;
                    r_route <= w_xy;
                end
            end
        end

`ifdef NOC_INPUTC_STATS_EN
        logic [15:0] r_flit_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)       r_flit_cnt <= '0;
            else if (w_rd[v]) r_flit_cnt <= r_flit_cnt + 16'd1;
        end
        assign flit_cnt_o[v*16 +: 16] = r_flit_cnt;
`else
        assign flit_cnt_o[v*16 +: 16] = 16'd0;
`endif
    end

    // Locked VC keeps the switch; otherwise first eligible VC from r_ptr.
    always_comb begin
        w_sel   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        if (r_state == ST_LOCKED) begin
            w_sel = r_lock_vc;
        end else begin
            for (int i = 0; i < VCH_N; i++) begin
                w_cand = VCH_W'((int'(r_ptr) + i) % VCH_N);
                if (!w_found && w_elig[w_cand]) begin
                    w_sel   = w_cand;
                    w_found = 1'b1;
                end
            end
        end
    end

    assign w_req      = w_elig[w_sel];
    assign w_pop      = w_req && bus.grt_i;
    assign w_pop_type = w_head[w_sel][DATA_W-1 -: 3];

    always_comb begin
        w_state_nx   = r_state;
        w_lock_vc_nx = r_lock_vc;
        w_ptr_nx     = r_ptr;
        if (w_pop) begin
            if (w_pop_type == c_T_HEAD) begin
                w_state_nx   = ST_LOCKED;
                w_lock_vc_nx = w_sel;
            end else if (w_pop_type == c_T_TAIL || w_pop_type == c_T_HEADTAIL) begin
                w_state_nx = ST_FREE;
                w_ptr_nx   = (w_sel == VCH_W'(VCH_N-1)) ? '0 : w_sel + VCH_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FREE;
            r_lock_vc   <= '0;
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_vch   <= '0;
            r_out_data  <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_lock_vc   <= w_lock_vc_nx;
            r_ptr       <= w_ptr_nx;
            r_out_valid <= w_pop;
            r_ovf       <= |w_full_hit;
            if (w_pop) begin
                r_out_vch  <= w_sel;
                r_out_data <= w_head[w_sel];
            end
        end
    end

    assign bus.in_rdy    = w_in_rdy;
    assign bus.req_o     = w_req;
    assign bus.port_o    = w_req ? w_route[w_sel] : 3'd0;
    assign bus.lck_o     = (r_state == ST_LOCKED);
    assign bus.out_valid = r_out_valid;
    assign bus.out_vch   = r_out_vch;
    assign bus.out_data  = r_out_data;
    assign overflow_o    = r_ovf;
endmodule

`default_nettype wire

// File: tb/tb_inputc_vcn.sv
// ============================================================================
// Module      : tb_inputc_vcn
// Description : Directed, table-driven bench for inputc_vcn (2 VCs, depth 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inputc_vcn;
    localparam int VCH_N = 2, DEPTH = 4, DATA_W = 32, ARRAY_W = 2, PORT_N = 5;
    localparam logic [9:0] c_DN = 10'h3FF;
    localparam logic [9:0] c_DL = 10'h3EF;   // EAST ready for VC0 low
    localparam logic [2:0] c_HT = 3'b100, c_H = 3'b001, c_B = 3'b010, c_T = 3'b011;

    logic clk = 1'b0;
    logic rst_n;
    logic [ARRAY_W-1:0] my_xpos, my_ypos;
    logic [PORT_N*VCH_N-1:0] dn_rdy;
    logic overflow_o;
    logic [VCH_N*16-1:0] flit_cnt_o;

    always #5 clk = ~clk;

    inputc_vcn_if #(.VCH_N(VCH_N), .DATA_W(DATA_W)) bus ();

    inputc_vcn #(
        .VCH_N(VCH_N), .DEPTH(DEPTH), .DATA_W(DATA_W), .ARRAY_W(ARRAY_W), .PORT_N(PORT_N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .my_xpos    (my_xpos),
        .my_ypos    (my_ypos),
        .dn_rdy     (dn_rdy),
        .overflow_o (overflow_o),
        .flit_cnt_o (flit_cnt_o)
    );

    typedef struct {
        logic        vld;
        logic [0:0]  vch;
        logic [31:0] data;
        logic        grt;
        logic [9:0]  dn;
        logic        req;
        logic [2:0]  port;
        logic        lck;
        logic        ov;
        logic [0:0]  ovch;
        logic [31:0] odata;
        logic [1:0]  rdy;
        logic        ovf;
    } vec_t;

    vec_t tv[$];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] mk(input logic [2:0] t, input logic [1:0] x,
                                       input logic [1:0] y, input logic [7:0] tag);
        return {t, 13'd0, tag, 4'd0, x, y};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic vld, input logic [0:0] vch, input logic [31:0] data,
                       input logic grt, input logic [9:0] dn, input logic req,
                       input logic [2:0] port, input logic lck, input logic ov,
                       input logic [0:0] ovch, input logic [31:0] odata,
                       input logic [1:0] rdy, input logic ovf);
        vec_t r;
        r.vld = vld; r.vch = vch; r.data = data; r.grt = grt; r.dn = dn;
        r.req = req; r.port = port; r.lck = lck; r.ov = ov; r.ovch = ovch;
        r.odata = odata; r.rdy = rdy; r.ovf = ovf;
        tv.push_back(r);
    endtask

    task automatic idle_in(input logic grt);
        bus.in_valid = 1'b0;
        bus.in_vch   = 1'b0;
        bus.in_data  = '0;
        bus.grt_i    = grt;
        dn_rdy       = c_DN;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " req_o"},     {31'd0, bus.req_o},     32'd0);
        chk({tag, " port_o"},    {29'd0, bus.port_o},    32'd0);
        chk({tag, " lck_o"},     {31'd0, bus.lck_o},     32'd0);
        chk({tag, " out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, " out_vch"},   {31'd0, bus.out_vch},   32'd0);
        chk({tag, " out_data"},  bus.out_data,           32'd0);
        chk({tag, " in_rdy"},    {30'd0, bus.in_rdy},    32'd3);
        chk({tag, " overflow"},  {31'd0, overflow_o},    32'd0);
        chk({tag, " flit_cnt"},  flit_cnt_o,             32'd0);
    endtask

    logic [31:0] fA, fB0, fB1, fB2, fB3, fC0H, fC1H, fC0T, fC1T;
    logic [31:0] fD0H, fD0B, fD1, fD0T, fE0, fE1, fE2, fE3, fE4, fE5, fR, fS;

    initial begin
        fA   = mk(c_HT, 2, 1, 8'h11);
        fB0  = mk(c_H, 1, 1, 8'h21); fB1 = mk(c_B, 1, 1, 8'h22);
        fB2  = mk(c_B, 1, 1, 8'h23); fB3 = mk(c_T, 1, 1, 8'h24);
        fC0H = mk(c_H, 0, 1, 8'h31); fC0T = mk(c_T, 0, 1, 8'h32);
        fC1H = mk(c_H, 1, 0, 8'h41); fC1T = mk(c_T, 1, 0, 8'h42);
        fD0H = mk(c_H, 2, 1, 8'h51); fD0B = mk(c_B, 2, 1, 8'h52);
        fD0T = mk(c_T, 2, 1, 8'h53); fD1  = mk(c_HT, 1, 1, 8'h61);
        fE0  = mk(c_H, 2, 1, 8'hA0); fE1 = mk(c_B, 2, 1, 8'hA1);
        fE2  = mk(c_B, 2, 1, 8'hA2); fE3 = mk(c_B, 2, 1, 8'hA3);
        fE4  = mk(c_B, 2, 1, 8'hA4); fE5 = mk(c_T, 2, 1, 8'hA5);
        fR   = mk(c_H, 2, 1, 8'h71); fS  = mk(c_HT, 1, 1, 8'h81);

        // vld vch data grt dn | req port lck ov ovch odata rdy ovf
        // single HEADTAIL VC0 -> EAST
        add(1,0,fA,1,c_DN, 0,0,0, 0,0,0,    3,0);
        add(0,0,0, 1,c_DN, 0,0,0, 0,0,0,    3,0);
        add(0,0,0, 1,c_DN, 1,2,0, 0,0,0,    3,0);
        add(0,0,0, 1,c_DN, 0,0,0, 1,0,fA,   3,0);
        add(0,0,0, 1,c_DN, 0,0,0, 0,0,0,    3,0);
        // 4-flit packet VC1 -> LOCAL
        add(1,1,fB0,1,c_DN, 0,0,0, 0,0,0,   3,0);
        add(1,1,fB1,1,c_DN, 0,0,0, 0,0,0,   3,0);
        add(1,1,fB2,1,c_DN, 1,0,0, 0,0,0,   3,0);
        add(1,1,fB3,1,c_DN, 1,0,1, 1,1,fB0, 3,0);
        add(0,0,0,  1,c_DN, 1,0,1, 1,1,fB1, 3,0);
        add(0,0,0,  1,c_DN, 1,0,1, 1,1,fB2, 3,0);
        add(0,0,0,  1,c_DN, 0,0,0, 1,1,fB3, 3,0);
        add(0,0,0,  1,c_DN, 0,0,0, 0,0,0,   3,0);
        // packets on both VCs, no interleave
        add(1,0,fC0H,1,c_DN, 0,0,0, 0,0,0,    3,0);
        add(1,1,fC1H,1,c_DN, 0,0,0, 0,0,0,    3,0);
        add(1,0,fC0T,1,c_DN, 1,4,0, 0,0,0,    3,0);
        add(1,1,fC1T,1,c_DN, 1,4,1, 1,0,fC0H, 3,0);
        add(0,0,0,   1,c_DN, 1,1,0, 1,0,fC0T, 3,0);
        add(0,0,0,   1,c_DN, 1,1,1, 1,1,fC1H, 3,0);
        add(0,0,0,   1,c_DN, 0,0,0, 1,1,fC1T, 3,0);
        add(0,0,0,   1,c_DN, 0,0,0, 0,0,0,    3,0);
        // locked VC0 stalls on downstream ready, VC1 waits
        add(1,0,fD0H,1,c_DN, 0,0,0, 0,0,0,    3,0);
        add(1,0,fD0B,1,c_DN, 0,0,0, 0,0,0,    3,0);
        add(1,1,fD1, 1,c_DN, 1,2,0, 0,0,0,    3,0);
        add(1,0,fD0T,1,c_DL, 0,0,1, 1,0,fD0H, 3,0);
        add(0,0,0,   1,c_DL, 0,0,1, 0,0,0,    3,0);
        add(0,0,0,   1,c_DL, 0,0,1, 0,0,0,    3,0);
        add(0,0,0,   1,c_DN, 1,2,1, 0,0,0,    3,0);
        add(0,0,0,   1,c_DN, 1,2,1, 1,0,fD0B, 3,0);
        add(0,0,0,   1,c_DN, 1,0,0, 1,0,fD0T, 3,0);
        add(0,0,0,   1,c_DN, 0,0,0, 1,1,fD1,  3,0);
        add(0,0,0,   1,c_DN, 0,0,0, 0,0,0,    3,0);
        // DEPTH+1 writes to VC0 without grant, then drain
        add(1,0,fE0,0,c_DN, 0,0,0, 0,0,0,    3,0);
        add(1,0,fE1,0,c_DN, 0,0,0, 0,0,0,    3,0);
        add(1,0,fE2,0,c_DN, 1,2,0, 0,0,0,    3,0);
        add(1,0,fE3,0,c_DN, 1,2,0, 0,0,0,    3,0);
        add(1,0,fE4,0,c_DN, 1,2,0, 0,0,0,    3,0);
        add(0,0,0,  0,c_DN, 1,2,0, 0,0,0,    2,1);
        add(0,0,0,  1,c_DN, 1,2,0, 0,0,0,    2,0);
        add(0,0,0,  1,c_DN, 1,2,1, 1,0,fE0,  2,0);
        add(0,0,0,  1,c_DN, 1,2,1, 1,0,fE1,  3,0);
        add(0,0,0,  1,c_DN, 1,2,1, 1,0,fE2,  3,0);
        add(0,0,0,  1,c_DN, 0,0,1, 1,0,fE3,  3,0);
        add(1,0,fE5,1,c_DN, 0,0,1, 0,0,0,    3,0);
        add(0,0,0,  1,c_DN, 1,2,1, 0,0,0,    3,0);
        add(0,0,0,  1,c_DN, 0,0,0, 1,0,fE5,  3,0);
        add(0,0,0,  1,c_DN, 0,0,0, 0,0,0,    3,0);

        rst_n   = 1'b0;
        my_xpos = 2'd1;
        my_ypos = 2'd1;
        idle_in(1'b0);
        repeat (2) @(posedge clk);
        #2;
        chk_reset_vals("in_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk_reset_vals("after_reset");

        for (int i = 0; i < tv.size(); i++) begin
            bus.in_valid = tv[i].vld;
            bus.in_vch   = tv[i].vch;
            bus.in_data  = tv[i].data;
            bus.grt_i    = tv[i].grt;
            dn_rdy       = tv[i].dn;
            #1;
            chk($sformatf("row%0d req_o", i),      {31'd0, bus.req_o},     {31'd0, tv[i].req});
            chk($sformatf("row%0d lck_o", i),      {31'd0, bus.lck_o},     {31'd0, tv[i].lck});
            chk($sformatf("row%0d out_valid", i),  {31'd0, bus.out_valid}, {31'd0, tv[i].ov});
            chk($sformatf("row%0d in_rdy", i),     {30'd0, bus.in_rdy},    {30'd0, tv[i].rdy});
            chk($sformatf("row%0d overflow_o", i), {31'd0, overflow_o},    {31'd0, tv[i].ovf});
            if (tv[i].req)
                chk($sformatf("row%0d port_o", i), {29'd0, bus.port_o},    {29'd0, tv[i].port});
            if (tv[i].ov) begin
                chk($sformatf("row%0d out_vch", i),  {31'd0, bus.out_vch}, {31'd0, tv[i].ovch});
                chk($sformatf("row%0d out_data", i), bus.out_data,         tv[i].odata);
            end
            @(posedge clk);
            #2;
        end

        idle_in(1'b1);
`ifdef NOC_INPUTC_STATS_EN
        chk("flit_cnt", flit_cnt_o, {16'd7, 16'd11});
`else
        chk("flit_cnt", flit_cnt_o, 32'd0);
`endif

        // Reset in the middle of a locked packet with a BODY still queued
        bus.in_valid = 1'b1; bus.in_vch = 1'b0; bus.in_data = fR;
        @(posedge clk); #2;
        bus.in_data = mk(c_B, 2, 1, 8'h72);
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("midpkt lck_o", {31'd0, bus.lck_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        bus.in_valid = 1'b1; bus.in_vch = 1'b0; bus.in_data = fS;
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("post_reset out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("post_reset out_data",  bus.out_data,           fS);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
